wormhole_output_arbiter: RTL and testbench

Per-output-port arbiter and flow controller for the 5-port wormhole mesh router. It picks one input FIFO per packet using round-robin among head flits. It holds that grant until the tail flit has passed, so flits from different packets never interleave. It honours the downstream ON/OFF signal and drives the registered output flit and write enable for its link. One instance sits behind each router output (N/E/S/W/Local), between the input buffers and the output link.

---
 rtl/wormhole_output_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_wormhole_output_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_output_arbiter.sv
// -----------------------------------------------------------------------------
// wormhole_output_arbiter
//
// Per-output arbiter and flow controller for a 5-port wormhole mesh router.
// While idle it picks one input whose head flit (HEAD or SINGLE) targets this
// output, searching round-robin from rr_ptr. The grant is then held until that
// packet's TAIL (or the SINGLE flit itself) has been forwarded, so packets never
// interleave on the link. Flits move only when the owner is requesting and the
// downstream ON/OFF signal allows it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req        per-input request: FIFO non-empty and head flit routed here
//   in_flits   head-of-queue flit of input i at [i*FLIT_SIZE +: FLIT_SIZE]
//   on_off     downstream back-pressure (1 = may send, 0 = stall)
//   grant      registered one-hot owner of this output, 0 when idle
//   rd_en      combinational FIFO pop = grant & req & {NUM_PORTS{on_off}}
//   out_flit   registered flit driven onto the link
//   out_wr_en  registered valid for out_flit
//   busy       high while a packet holds the output
//   err        sticky protocol error (BODY/TAIL seen at head while idle)
// -----------------------------------------------------------------------------
module wormhole_output_arbiter #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned FLIT_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*FLIT_SIZE-1:0] in_flits,
    input  logic                           on_off,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS-1:0]           rd_en,
    output logic [FLIT_SIZE-1:0]           out_flit,
    output logic                           out_wr_en,
    output logic                           busy,
    output logic                           err
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Flit type encodings carried in the top two bits of every flit.
    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b01;
    localparam logic [1:0] TYPE_HEAD   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]           state_q,    state_d;
    logic [NUM_PORTS-1:0] grant_q,    grant_d;
    logic [PW-1:0]        owner_q,    owner_d;
    logic [PW-1:0]        rr_ptr_q,   rr_ptr_d;
    logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
    logic                 out_wr_q,   out_wr_d;
    logic                 err_q,      err_d;

    // -------------------------------------------------------------------------
    // Per-input flit decode
    // -------------------------------------------------------------------------
    logic [FLIT_SIZE-1:0] flit_arr [NUM_PORTS];
    logic [1:0]           ftype    [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] bad_head;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            flit_arr[i] = in_flits[i*FLIT_SIZE +: FLIT_SIZE];
            ftype[i]    = flit_arr[i][FLIT_SIZE-1 -: 2];
            eligible[i] = req[i] && ((ftype[i] == TYPE_HEAD) || (ftype[i] == TYPE_SINGLE));
            bad_head[i] = req[i] && ((ftype[i] == TYPE_BODY) || (ftype[i] == TYPE_TAIL));
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin search starting at rr_ptr_q. The index is formed one bit
    // wider than rr_ptr so rr_ptr + k cannot overflow before the explicit wrap.
    // -------------------------------------------------------------------------
    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW:0]   probe;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            probe = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (probe >= (PW+1)'(NUM_PORTS)) begin
                probe = probe - (PW+1)'(NUM_PORTS);
            end
            if (!win_found && eligible[probe[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[PW-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Owner-side transfer decode
    // -------------------------------------------------------------------------
    logic [FLIT_SIZE-1:0] owner_flit;
    logic [1:0]           owner_type;
    logic                 xfer;
    logic                 owner_last;
    logic [PW-1:0]        owner_next;

    always_comb begin
        owner_flit = flit_arr[owner_q];
        owner_type = owner_flit[FLIT_SIZE-1 -: 2];
        xfer       = (state_q == ST_LOCKED) && req[owner_q] && on_off;
        owner_last = (owner_type == TYPE_TAIL) || (owner_type == TYPE_SINGLE);
        if (owner_q == PW'(NUM_PORTS-1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + PW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        out_flit_d = out_flit_q;
        out_wr_d   = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                // A non-head flit presented at the head of a queue while no
                // packet is open means the upstream framing is broken.
                if (|bad_head) begin
                    err_d = 1'b1;
                end
                // Arbitration happens regardless of on_off; nothing moves
                // this cycle because grant_q is still zero.
                if (win_found) begin
                    state_d          = ST_LOCKED;
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end
            default: begin
                // A stall (owner FIFO empty or downstream OFF) keeps the lock
                // and ignores every other request; rr_ptr only moves when the
                // packet completes.
                if (xfer) begin
                    out_flit_d = owner_flit;
                    out_wr_d   = 1'b1;
                    if (owner_last) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = owner_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            out_flit_q <= '0;
            out_wr_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            out_flit_q <= out_flit_d;
            out_wr_q   <= out_wr_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign grant     = grant_q;
    assign rd_en     = grant_q & req & {NUM_PORTS{on_off}};
    assign out_flit  = out_flit_q;
    assign out_wr_en = out_wr_q;
    assign busy      = (state_q == ST_LOCKED);
    assign err       = err_q;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));
    a_grant_iff_locked : assert property (@(posedge clk) disable iff (!rst)
        ((state_q == ST_LOCKED) == (grant_q != '0)));
    a_rr_in_range : assert property (@(posedge clk) disable iff (!rst)
        (rr_ptr_q < PW'(NUM_PORTS)));

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wormhole_output_arbiter
//
// Self-checking bench for wormhole_output_arbiter. Each input is fed from a
// packet queue; a behavioural model tracks ownership, round-robin pointer,
// output register and error flag, and every cycle the DUT outputs are compared
// against it. Directed scenarios add literal expectations on recorded traces.
// -----------------------------------------------------------------------------
module tb_wormhole_output_arbiter;

    localparam int NP = 5;
    localparam int FW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      req;
    logic [NP*FW-1:0]   in_flits;
    logic               on_off;
    logic [NP-1:0]      grant;
    logic [NP-1:0]      rd_en;
    logic [FW-1:0]      out_flit;
    logic               out_wr_en;
    logic               busy;
    logic               err;

    wormhole_output_arbiter #(
        .NUM_PORTS (NP),
        .FLIT_SIZE (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_flits  (in_flits),
        .on_off    (on_off),
        .grant     (grant),
        .rd_en     (rd_en),
        .out_flit  (out_flit),
        .out_wr_en (out_wr_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Input packet queues and per-cycle presence gates
    logic [FW-1:0] fq [NP][$];
    bit            gate [NP];
    bit            onoff_v;

    // Behavioural model
    bit        m_locked;
    int        m_owner;
    int        m_rr;
    bit [7:0]  m_out;
    bit        m_wr;
    bit        m_err;

    // Traces for directed literal checks
    logic [NP-1:0] grlog [$];
    logic [NP-1:0] rdlog [$];
    logic          wrlog [$];
    logic [FW-1:0] outlog [$];

    int vecs = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int i);
        logic [NP-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit is_last(input logic [FW-1:0] f);
        return (f[7:6] == 2'b01) || (f[7:6] == 2'b11);
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_out    = '0;
        m_wr     = 0;
        m_err    = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) begin
            fq[i].delete();
            gate[i] = 1;
        end
        grlog.delete();
        rdlog.delete();
        wrlog.delete();
        outlog.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        in_flits = '0;
        on_off = 1'b1;
        clear_all();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs on the falling edge, compare, advance model.
    task automatic step();
        logic [NP-1:0] exp_rd;
        logic [FW-1:0] f;
        int            winner;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (fq[i].size() > 0 && gate[i]) begin
                req[i] = 1'b1;
                in_flits[i*FW +: FW] = fq[i][0];
            end else begin
                req[i] = 1'b0;
                in_flits[i*FW +: FW] = FW'($urandom);
            end
        end
        on_off = onoff_v;
        #1;
        exp_rd = (m_locked && req[m_owner] && on_off) ? onehot(m_owner) : '0;
        chk("grant",     32'(grant),     m_locked ? 32'(onehot(m_owner)) : 32'd0);
        chk("rd_en",     32'(rd_en),     32'(exp_rd));
        chk("out_wr_en", 32'(out_wr_en), 32'(m_wr));
        chk("out_flit",  32'(out_flit),  32'(m_out));
        chk("busy",      32'(busy),      32'(m_locked));
        chk("err",       32'(err),       32'(m_err));
        grlog.push_back(grant);
        rdlog.push_back(rd_en);
        wrlog.push_back(out_wr_en);
        if (out_wr_en) outlog.push_back(out_flit);

        // Model advance to the next edge
        if (!m_locked) begin
            m_wr = 0;
            winner = -1;
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_rr + k) % NP;
                f = in_flits[i*FW +: FW];
                if (winner < 0 && req[i] && (f[7:6] == 2'b10 || f[7:6] == 2'b11)) winner = i;
            end
            for (int i = 0; i < NP; i++) begin
                f = in_flits[i*FW +: FW];
                if (req[i] && (f[7:6] == 2'b00 || f[7:6] == 2'b01)) m_err = 1;
            end
            if (winner >= 0) begin
                m_locked = 1;
                m_owner  = winner;
            end
        end else if (req[m_owner] && on_off) begin
            f = fq[m_owner].pop_front();
            m_out = f;
            m_wr  = 1;
            if (is_last(f)) begin
                m_locked = 0;
                m_rr     = (m_owner + 1) % NP;
            end
        end else begin
            m_wr = 0;
        end
    endtask

    task automatic steps(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic push_packet(input int port, input int len);
        logic [1:0] t;
        logic [5:0] pay;
        for (int j = 0; j < len; j++) begin
            if (len == 1)           t = 2'b11;
            else if (j == 0)        t = 2'b10;
            else if (j == len - 1)  t = 2'b01;
            else                    t = ($urandom % 10 == 0) ? 2'b10 : 2'b00;
            pay = 6'($urandom);
            fq[port].push_back({t, pay});
        end
    endtask

    function automatic logic [NP-1:0] first_grant_from(input int start);
        for (int c = start; c < grlog.size(); c++) begin
            if (grlog[c] != '0) return grlog[c];
        end
        return '0;
    endfunction

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int mark;
        rst = 1'b0;
        req = '0;
        in_flits = '0;
        on_off = 1'b1;
        onoff_v = 1'b1;
        clear_all();
        model_reset();
        #1;
        chk("reset_grant", 32'(grant),     32'd0);
        chk("reset_wr",    32'(out_wr_en), 32'd0);
        chk("reset_busy",  32'(busy),      32'd0);
        do_reset();

        // Single 4-flit packet on port 2
        fq[2].push_back(8'h85); fq[2].push_back(8'h11);
        fq[2].push_back(8'h22); fq[2].push_back(8'h43);
        steps(7);
        chk("p2_grant_c1", 32'(grlog[1]), 32'h04);
        chk("p2_rd_c1",    32'(rdlog[1]), 32'h04);
        chk("p2_rd_c4",    32'(rdlog[4]), 32'h04);
        chk("p2_rd_c5",    32'(rdlog[5]), 32'h00);
        chk("p2_wr_c1",    32'(wrlog[1]), 32'd0);
        chk("p2_wr_c2",    32'(wrlog[2]), 32'd1);
        chk("p2_wr_c5",    32'(wrlog[5]), 32'd1);
        chk("p2_wr_c6",    32'(wrlog[6]), 32'd0);
        chk("p2_nflits",   32'(outlog.size()), 32'd4);
        if (outlog.size() == 4) begin
            chk("p2_f0", 32'(outlog[0]), 32'h85);
            chk("p2_f1", 32'(outlog[1]), 32'h11);
            chk("p2_f2", 32'(outlog[2]), 32'h22);
            chk("p2_f3", 32'(outlog[3]), 32'h43);
        end
        // rr_ptr now 3: singles on 0 and 4 -> port 4 must win first
        mark = grlog.size();
        fq[0].push_back(8'hC1);
        fq[4].push_back(8'hC2);
        steps(6);
        chk("rr_after_p2", 32'(first_grant_from(mark)), 32'h10);

        // Two 2-flit packets on ports 0 and 3 arriving together
        do_reset();
        fq[0].push_back(8'h80); fq[0].push_back(8'h40);
        fq[3].push_back(8'h80); fq[3].push_back(8'h40);
        steps(8);
        chk("two_g1", 32'(grlog[1]), 32'h01);
        chk("two_g3", 32'(grlog[3]), 32'h00);
        chk("two_g4", 32'(grlog[4]), 32'h08);
        chk("two_n",  32'(outlog.size()), 32'd4);
        if (outlog.size() == 4) begin
            chk("two_f0", 32'(outlog[0]), 32'h80);
            chk("two_f1", 32'(outlog[1]), 32'h40);
            chk("two_f2", 32'(outlog[2]), 32'h80);
            chk("two_f3", 32'(outlog[3]), 32'h40);
        end
        // rr_ptr now 4: singles on 3 and 0 -> port 0 must win first
        mark = grlog.size();
        fq[3].push_back(8'hC3);
        fq[0].push_back(8'hC4);
        steps(6);
        chk("rr_after_two", 32'(first_grant_from(mark)), 32'h01);

        // Port 1 mid-packet when port 4 head arrives; then stalls
        do_reset();
        fq[1].push_back(8'h81); fq[1].push_back(8'h02);
        fq[1].push_back(8'h03); fq[1].push_back(8'h44);
        steps(3);
        fq[4].push_back(8'h9A); fq[4].push_back(8'h5B);
        onoff_v = 1'b0;
        steps(3);
        onoff_v = 1'b1;
        gate[1] = 0;
        steps(2);
        gate[1] = 1;
        steps(8);

        // SINGLE flit on port 0
        do_reset();
        fq[0].push_back(8'hC7);
        steps(4);
        chk("single_n", 32'(outlog.size()), 32'd1);
        chk("single_busy_end", 32'(busy), 32'd0);

        // Protocol error, then asynchronous reset mid-packet
        do_reset();
        fq[0].push_back(8'h12);
        steps(3);
        chk("err_set",     32'(err),   32'd1);
        chk("err_nogrant", 32'(grant), 32'd0);
        fq[0].delete();
        fq[1].push_back(8'h81); fq[1].push_back(8'h02);
        fq[1].push_back(8'h03); fq[1].push_back(8'h44);
        steps(3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 32'(grant),     32'd0);
        chk("arst_wr",    32'(out_wr_en), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_err",   32'(err),       32'd0);
        chk("arst_rd",    32'(rd_en),     32'd0);
        do_reset();

        // Randomized traffic with stalls, empty gaps and back-pressure
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (fq[i].size() < 2 && ($urandom % 4 == 0)) push_packet(i, 1 + int'($urandom % 5));
                gate[i] = ($urandom % 8) != 0;
            end
            onoff_v = ($urandom % 5) != 0;
            step();
        end
        onoff_v = 1'b1;
        for (int i = 0; i < NP; i++) gate[i] = 1;
        steps(60);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
